// File: rtl/nco_rx_monitor.sv
// rtl/nco_rx_monitor.sv - NCO receive-side period/peak monitor
//
// Watches the NCO sample stream and finds rising zero crossings. It counts the
// valid samples between two consecutive crossings and tracks the signed peak
// over that span. Each measurement is handed off through a Vout/Rdy handshake.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   En          monitor enable; low forces IDLE and drops Vout
//   selSign     1 = two's complement samples, 0 = offset binary
//   Vld, Din    sample strobe and sample
//   Rdy         downstream accepts the current result
//   Vout        Period/Peak/Ovf hold a fresh measurement
//   Period      valid-sample count between consecutive rising crossings
//   Peak        signed maximum sample within the measured span
//   Ovf         counter saturated before a crossing; Period is all ones
//   Busy        registered flag, high in SEEK or MEAS
module nco_rx_monitor #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          En,
  input  logic          selSign,
  input  logic          Vld,
  input  logic [DW-1:0] Din,
  input  logic          Rdy,
  output logic          Vout,
  output logic [CW-1:0] Period,
  output logic [DW-1:0] Peak,
  output logic          Ovf,
  output logic          Busy
);

  typedef enum logic [1:0] {IDLE, SEEK, MEAS, HOLD} state_t;

  localparam logic signed [DW-1:0] PK_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t               state;
  logic                 prev_ok;
  logic                 prev_neg;
  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] pk;

  logic signed [DW-1:0] s;
  logic signed [DW-1:0] pk_next;
  logic [CW-1:0]        cnt_inc;
  logic                 crossing;
  logic                 cnt_full;

  // Offset binary becomes two's complement by flipping the MSB.
  assign s        = selSign ? Din : {~Din[DW-1], Din[DW-2:0]};
  assign pk_next  = (s > pk) ? s : pk;
  assign cnt_inc  = cnt + CNT_ONE;
  assign cnt_full = (cnt_inc == {CW{1'b1}});
  // prev_neg only tracks valid samples, so Vld=0 gaps keep adjacency intact.
  assign crossing = Vld && prev_ok && prev_neg && !s[DW-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      prev_ok  <= 1'b0;
      prev_neg <= 1'b0;
      cnt      <= '0;
      pk       <= '0;
      Vout     <= 1'b0;
      Period   <= '0;
      Peak     <= '0;
      Ovf      <= 1'b0;
      Busy     <= 1'b0;
    end else if (!En) begin
      // Disable overrides everything, including a handshake in this cycle.
      state   <= IDLE;
      prev_ok <= 1'b0;
      Vout    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= SEEK;
          prev_ok <= 1'b0;
          Busy    <= 1'b1;
        end
        SEEK: begin
          if (Vld) begin
            prev_ok  <= 1'b1;
            prev_neg <= s[DW-1];
            if (crossing) begin
              cnt   <= '0;
              pk    <= PK_MIN;
              state <= MEAS;
            end
          end
        end
        MEAS: begin
          if (Vld) begin
            prev_neg <= s[DW-1];
            cnt      <= cnt_inc;
            pk       <= pk_next;
            if (crossing || cnt_full) begin
              // A crossing on the saturating sample still counts as a clean period.
              Period <= crossing ? cnt_inc : {CW{1'b1}};
              Ovf    <= !crossing;
              Peak   <= pk_next;
              Vout   <= 1'b1;
              Busy   <= 1'b0;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          // Vout is always high here; samples are dropped until accepted.
          if (Rdy) begin
            Vout    <= 1'b0;
            prev_ok <= 1'b0;
            Busy    <= 1'b1;
            state   <= SEEK;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nco_rx_monitor.md
# nco_rx_monitor

Receive-side monitor for the NCO sample stream: consumes the `Vld`/`Dout` output of the NCO top and measures the period and positive peak of each waveform cycle. It detects rising zero crossings and counts valid samples between consecutive crossings. It also tracks the maximum sample over that span. Each measurement is delivered through a Vout/Rdy handshake, so the block closes the loop on the NCO tone in verification and in on-chip self-test.

## Interface
- `DW`, 12: sample width; matches NCO `Dout`.
- `CW`, 16: period counter and `Period` width.
- `clk` in 1: single clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `En` in 1: monitor enable; 0 forces IDLE.
- `selSign` in 1: sample format; 1 = two's complement, 0 = offset binary (midscale 0x800).
- `Vld` in 1: `Din` holds a valid sample this cycle.
- `Din` in DW: NCO sample.
- `Rdy` in 1: downstream accepts the result.
- `Vout` out 1: `Period`/`Peak`/`Ovf` valid.
- `Period` out CW: valid-sample count between two consecutive rising crossings.
- `Peak` out DW: signed max sample in the measured span.
- `Ovf` out 1: period counter saturated; `Period` = all ones.
- `Busy` out 1: state is SEEK or MEAS.

## Operation
- Sample normalisation: s = selSign ? Din : {~Din[DW-1], Din[DW-2:0]}; s is signed DW-bit.
- Rising crossing: a valid sample with s >= 0 whose previous valid sample had s < 0. Cycles with Vld=0 are ignored entirely and do not break adjacency.
- `prev_ok` flag: set on the first valid sample after entering SEEK; cleared on entry to IDLE or SEEK. No crossing is declared without prev_ok=1.
- FSM states:
  - IDLE: entered on reset or En=0. Vout=0. Moves to SEEK when En=1.
  - SEEK: waits for a rising crossing. On a crossing: cnt<=0, pk<=-2^(DW-1), go to MEAS.
  - MEAS: on each valid sample, cnt<=cnt+1 and pk<=max(pk,s).
    - On a crossing: Period<=cnt+1, Peak<=max(pk,s), Ovf<=0, Vout<=1, go to HOLD.
    - If cnt+1 reaches 2^CW-1 without a crossing: Period<=all ones, Peak<=max(pk,s), Ovf<=1, Vout<=1, go to HOLD.
  - HOLD: samples ignored, outputs stable. When Vout&Rdy, Vout<=0 and go to SEEK; a fresh crossing is required for the next measurement.
- En=0 in any state: next state IDLE, Vout<=0. Period/Peak/Ovf hold their last values.
- Arithmetic: cnt is CW bits and never wraps. Peak compare is signed.

## Timing
- Reset values: Vout=0, Period=0, Peak=0, Ovf=0, Busy=0, state IDLE, prev_ok=0, cnt=0, pk=0.
- Latency: the ending crossing sample is sampled at edge t; Vout=1 and Period/Peak are valid after edge t.
- Handshake completes on an edge where Vout=1 and Rdy=1. Rdy held high gives a one-cycle Vout pulse. Rdy=0 holds Vout and the data indefinitely.
- Measurements that complete while in HOLD are not recorded: there is no queueing and no overwrite.
- Crossing on the first valid sample after leaving HOLD or IDLE: ignored (prev_ok=0).
- En falling in the same cycle as the handshake: IDLE wins and Vout<=0.
- rstn asserted mid-measurement: immediate return to reset values, with no Vout glitch after deassertion.
- Busy is registered from state and has no combinational path from inputs.

## Test plan
- Two's-complement sine with period 64 samples, Vld every cycle, Rdy=1:
  - every Period=64, Peak=2047 ±1 LSB.
  - first Vout arrives after the second rising crossing.
- Same sine with Vld toggling 1-0-1-0: Period still 64. Vout rises one cycle after the ending crossing sample.
- Offset-binary ramp 0x000..0xFFF repeating, selSign=0: Period=4096 (CW=16), Peak=2047.
- Rdy held 0 for 500 cycles during HOLD: Vout, Period and Peak stay stable. Releasing Rdy gives a one-cycle handshake and a return to SEEK. The next Vout arrives only after two new crossings.
- CW=8, Din=-5 then constant +100 forever: Ovf=1, Period=255, Peak=100, Vout=1.
- Reset and enable disruptions:
  - En=0 mid-MEAS: immediate IDLE, Busy=0, no Vout. Re-enabling restarts SEEK.
  - rstn pulsed low mid-HOLD: all outputs return to 0 asynchronously.
